// File: rtl/dual_port_ram_be_pkg.sv
// Shared types, latency limits and the byte-lane merge helper for the
// byte-enabled dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    // Called as byte_merge_c#(DW, BW)::byte_merge(...) so the widths follow the caller.
    virtual class byte_merge_c #(parameter int DW = 32, parameter int BW = 8);
        static function logic [DW-1:0] byte_merge(
            input logic [DW-1:0]    old_word,
            input logic [DW-1:0]    new_word,
            input logic [DW/BW-1:0] be
        );
            logic [DW-1:0] merged;
            merged = old_word;
            for (int i = 0; i < DW/BW; i++) begin
                if (be[i]) merged[i*BW +: BW] = new_word[i*BW +: BW];
            end
            return merged;
        endfunction
    endclass

endpackage

// File: rtl/dual_port_ram_be_if.sv
// Write, read and clear signals between the FIFO controller (master) and the
// byte-enabled RAM (slave).
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_en;
    logic [NB-1:0]         wr_be;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  rd_valid;
    logic                  clr_req;
    logic                  clr_busy;

    modport master (
        output wr_en, wr_be, write_addr, write_data, rd_en, read_addr, clr_req,
        input  wr_ready, read_data, rd_valid, clr_busy
    );

    modport slave (
        input  wr_en, wr_be, write_addr, write_data, rd_en, read_addr, clr_req,
        output wr_ready, read_data, rd_valid, clr_busy
    );

endinterface

// File: rtl/dual_port_ram_be_rd_pipe.sv
// Read-return register chain: RD_LATENCY stages of {valid, data}; data only
// advances with a valid so the output word holds between strobes.
module ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LATENCY-1];
    assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_be.sv
// Single-clock simple dual-port RAM with byte enables, pipelined reads and a
// sequential clear sweep (after reset and on request).
//   state | meaning
//   IDLE  | normal operation, reads and writes accepted
//   CLEAR | zeroing mem[clr_addr] each cycle, reads/writes ignored
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input logic               wr_clk,
    input logic               reset_n,
    dual_port_ram_be_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ram_state_e            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rdw_hit;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_fire = bus.wr_en && (state == IDLE);
    assign rd_fire = bus.rd_en && (state == IDLE);
    assign wr_word = byte_merge_c#(DATA_WIDTH, BYTE_WIDTH)::byte_merge(
                         mem[bus.write_addr], bus.write_data, bus.wr_be);

    // Same-address collision: wr_word is exactly the merged word the read would see afterwards.
    assign rdw_hit = (RDW_MODE == 1) && wr_fire && (bus.write_addr == bus.read_addr);
    assign rd_word = rdw_hit ? wr_word : mem[bus.read_addr];

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) state <= IDLE;
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // The array has no reset; the sweep is what brings it to zero.
    always_ff @(posedge wr_clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem[bus.write_addr] <= wr_word;
        end
    end

    assign bus.clr_busy = (state == CLEAR);
    assign bus.wr_ready = (state == IDLE);

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (wr_clk),
        .reset_n   (reset_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (bus.rd_valid),
        .out_data  (bus.read_data)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: two RAM instances (latency 1/old-data and latency 2/new-data)
// share one stimulus stream and are checked against an array-based reference model.
module tb_dual_port_ram_be;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [NB-1:0] wr_be = '0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic          clr_req = 1'b0;

    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus_a ();
    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus_b ();

    assign bus_a.wr_en      = wr_en;
    assign bus_a.wr_be      = wr_be;
    assign bus_a.write_addr = write_addr;
    assign bus_a.write_data = write_data;
    assign bus_a.rd_en      = rd_en;
    assign bus_a.read_addr  = read_addr;
    assign bus_a.clr_req    = clr_req;
    assign bus_b.wr_en      = wr_en;
    assign bus_b.wr_be      = wr_be;
    assign bus_b.write_addr = write_addr;
    assign bus_b.write_data = write_data;
    assign bus_b.rd_en      = rd_en;
    assign bus_b.read_addr  = read_addr;
    assign bus_b.clr_req    = clr_req;

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .wr_clk  (clk),
        .reset_n (rst_n),
        .bus     (bus_a)
    );

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .wr_clk  (clk),
        .reset_n (rst_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            mon_on = 1'b0;
    logic [DW-1:0] mem_m [DEPTH];
    bit            model_busy = 1'b1;
    int            sweep_left = DEPTH;
    exp_t          sb [2][$];
    logic [DW-1:0] last_data [2];

    function automatic int lat_of(int p);
        return (p == 0) ? 1 : 2;
    endfunction

    function automatic bit new_data_of(int p);
        return p == 1;
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < NB; i++) if (be[i]) r[i*BW +: BW] = n[i*BW +: BW];
        return r;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock edge of the reference: sweep countdown, or read/write/clear in idle.
    task automatic model_step();
        logic [DW-1:0] old_w;
        logic [DW-1:0] exp_w;
        exp_t          e;
        if (model_busy) begin
            sweep_left--;
            if (sweep_left == 0) model_busy = 1'b0;
        end else begin
            if (rd_en) begin
                old_w = mem_m[read_addr];
                for (int p = 0; p < 2; p++) begin
                    exp_w = old_w;
                    if (new_data_of(p) && wr_en && write_addr == read_addr)
                        exp_w = merge(old_w, write_data, wr_be);
                    e.data = exp_w;
                    e.due  = cyc + lat_of(p) - 1;
                    sb[p].push_back(e);
                end
            end
            if (wr_en) mem_m[write_addr] = merge(mem_m[write_addr], write_data, wr_be);
            if (clr_req) begin
                model_busy = 1'b1;
                sweep_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        #2;
    endtask

    task automatic drive(bit we, logic [NB-1:0] be, logic [AW-1:0] wa, logic [DW-1:0] wd,
                         bit re, logic [AW-1:0] ra, bit cr);
        wr_en = we; wr_be = be; write_addr = wa; write_data = wd;
        rd_en = re; read_addr = ra; clr_req = cr;
        tick();
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Counts busy cycles while throwing random writes/reads at the sweep; optional clr_req pulse.
    task automatic busy_len(string name, int pulse_at);
        int n;
        n = 0;
        while (bus_a.clr_busy === 1'b1 && n < 20) begin
            drive(1'($urandom_range(0, 1)), 4'hF, AW'($urandom), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom), n == pulse_at);
            n++;
        end
        check(name, DW'(n), DW'(DEPTH));
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            sb[p].delete();
            last_data[p] = '0;
        end
        model_busy = 1'b1;
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        #1;
        check("reset_read_data_a", bus_a.read_data, '0);
        check("reset_rd_valid_a", DW'(bus_a.rd_valid), '0);
        check("reset_read_data_b", bus_b.read_data, '0);
        check("reset_rd_valid_b", DW'(bus_b.rd_valid), '0);
        mon_on = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic watch(int p, logic valid, logic [DW-1:0] data, logic busy, logic ready);
        exp_t e;
        check($sformatf("clr_busy_%0d", p), DW'(busy), DW'(model_busy));
        check($sformatf("wr_ready_%0d", p), DW'(ready), DW'(!model_busy));
        if (valid === 1'b1) begin
            if (sb[p].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid_%0d actual=1 required=0 (cycle %0d)", p, cyc);
            end else begin
                e = sb[p].pop_front();
                check($sformatf("read_data_%0d", p), data, e.data);
                check($sformatf("rd_valid_cycle_%0d", p), DW'(cyc), DW'(e.due));
                last_data[p] = e.data;
            end
        end else begin
            check($sformatf("rd_valid_low_%0d", p), DW'(valid), '0);
            check($sformatf("read_data_hold_%0d", p), data, last_data[p]);
            if (sb[p].size() != 0 && sb[p][0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rd_valid_%0d actual=0 required=1 (cycle %0d)", p, cyc);
                void'(sb[p].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            watch(0, bus_a.rd_valid, bus_a.read_data, bus_a.clr_busy, bus_a.wr_ready);
            watch(1, bus_b.rd_valid, bus_b.read_data, bus_b.clr_busy, bus_b.wr_ready);
        end
    end

    initial begin
        #1;
        do_reset();

        // Post-reset sweep, then read of a cleared word.
        busy_len("post_reset_sweep_len", -1);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd5, 1'b0);
        idle(2);

        // Byte-enable merge on addr 2.
        drive(1'b1, 4'hF, 3'd2, 32'hAABBCCDD, 1'b0, '0, 1'b0);
        drive(1'b1, 4'b0101, 3'd2, 32'h11223344, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd2, 1'b0);

        // Read-during-write on addr 3, then read it back.
        drive(1'b1, 4'hF, 3'd3, 32'hDEADBEEF, 1'b1, 3'd3, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd3, 1'b0);
        idle(3);

        // Fill, stream all addresses back-to-back, runtime clear with a mid-sweep pulse.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'hF, AW'(i), $urandom, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        busy_len("runtime_clear_len", 3);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);

        // Reset four cycles into a sweep, with non-zero read data on the outputs.
        drive(1'b1, 4'hF, 3'd1, 32'h12345678, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b1);
        idle(3);
        do_reset();
        busy_len("sweep_after_reset_len", -1);

        // Random traffic with occasional clears.
        repeat (400) begin
            drive(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(0, 60) == 0);
        end
        idle(4);
        check("scoreboard_drained_a", DW'(sb[0].size()), '0);
        check("scoreboard_drained_b", DW'(sb[1].size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
